// File: rtl/ru_wr_arbiter.sv
// Round-robin arbiter sharing the register-bank write port among NREQ writeback sources.
// The winning request is registered, so the bank sees at most one clean write per cycle.
module ru_wr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*AW-1:0]        req_rd,
    input  logic [NREQ*XLEN-1:0]      req_data,
    output logic [AW-1:0]             rd,
    output logic [XLEN-1:0]           DataWr,
    output logic                      RUWr,
    output logic [$clog2(NREQ)-1:0]   grant_idx
);

    localparam int unsigned IW = $clog2(NREQ);
    // One spare bit so ptr + k can exceed NREQ before the modulo fold.
    localparam int unsigned SW = IW + 1;

    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   win_idx;
    logic            win_found;
    logic [SW-1:0]   idx_sum;
    logic [AW-1:0]   sel_rd;
    logic [XLEN-1:0] sel_data;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx_sum   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx_sum = {1'b0, ptr_q} + SW'(k);
            if (idx_sum >= SW'(NREQ)) begin
                idx_sum = idx_sum - SW'(NREQ);
            end
            if (!win_found && req_valid[idx_sum[IW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = idx_sum[IW-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        sel_rd    = '0;
        sel_data  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_idx == IW'(i)) begin
                req_ready[i] = win_found;
                sel_rd       = req_rd[i*AW +: AW];
                sel_data     = req_data[i*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (win_found) begin
            ptr_d = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + IW'(1);
        end
    end

    // A transfer happens exactly when a winner exists, since ready is driven only for it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd        <= '0;
            DataWr    <= '0;
            RUWr      <= 1'b0;
            grant_idx <= '0;
            ptr_q     <= '0;
        end else begin
            RUWr  <= 1'b0;
            ptr_q <= ptr_d;
            if (win_found) begin
                rd        <= sel_rd;
                DataWr    <= sel_data;
                RUWr      <= (sel_rd != '0);
                grant_idx <= win_idx;
            end
        end
    end

endmodule

// File: tb/tb_ru_wr_arbiter.sv
// Bench for ru_wr_arbiter: a 4-requester instance checked against a round-robin model through
// a scoreboard, plus a 3-requester instance for non-power-of-two pointer wrap.
module tb_ru_wr_arbiter;

    localparam int AW   = 5;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [3:0]        a_valid, a_ready;
    logic [4*AW-1:0]   a_rd;
    logic [4*XLEN-1:0] a_data;
    logic [AW-1:0]     a_wr_rd;
    logic [XLEN-1:0]   a_wr_data;
    logic              a_we;
    logic [1:0]        a_gidx;

    logic [2:0]        b_valid, b_ready;
    logic [3*AW-1:0]   b_rd;
    logic [3*XLEN-1:0] b_data;
    logic [AW-1:0]     b_wr_rd;
    logic [XLEN-1:0]   b_wr_data;
    logic              b_we;
    logic [1:0]        b_gidx;

    ru_wr_arbiter #(.NREQ(4), .XLEN(XLEN), .AW(AW)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_ready(a_ready),
        .req_rd(a_rd), .req_data(a_data), .rd(a_wr_rd), .DataWr(a_wr_data),
        .RUWr(a_we), .grant_idx(a_gidx)
    );

    ru_wr_arbiter #(.NREQ(3), .XLEN(XLEN), .AW(AW)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_ready(b_ready),
        .req_rd(b_rd), .req_data(b_data), .rd(b_wr_rd), .DataWr(b_wr_data),
        .RUWr(b_we), .grant_idx(b_gidx)
    );

    typedef struct {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
        logic            we;
        logic [1:0]      gidx;
    } wr_t;

    int  n_tests = 0;
    int  n_fail  = 0;
    wr_t sb_q[$];
    int  m_ptr;
    wr_t m_out;
    int  wt[4];

    function automatic int pick(int ptr, int n, logic [7:0] valid);
        for (int k = 0; k < n; k++) begin
            if (valid[(ptr + k) % n]) return (ptr + k) % n;
        end
        return -1;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after inputs are driven (between edges); returns the model's winner.
    task automatic step_a(output int w);
        wr_t e;
        #1;
        w = pick(m_ptr, 4, {4'b0, a_valid});
        check("a_ready", 64'(a_ready), (w < 0) ? 64'd0 : (64'd1 << w));
        e    = m_out;
        e.we = 1'b0;
        if (w >= 0) begin
            e.rd   = a_rd[w*AW +: AW];
            e.data = a_data[w*XLEN +: XLEN];
            e.we   = (e.rd != '0);
            e.gidx = 2'(w);
            m_ptr  = (w + 1) % 4;
        end
        m_out = e;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        #1;
        e = sb_q.pop_front();
        check("a_RUWr", 64'(a_we), 64'(e.we));
        check("a_rd", 64'(a_wr_rd), 64'(e.rd));
        check("a_DataWr", 64'(a_wr_data), 64'(e.data));
        check("a_grant_idx", 64'(a_gidx), 64'(e.gidx));
    endtask

    task automatic reset_all();
        a_valid = '0;
        b_valid = '0;
        rst_n   = 1'b0;
        #1;
        check("rst_a_RUWr", 64'(a_we), 64'd0);
        check("rst_a_rd", 64'(a_wr_rd), 64'd0);
        check("rst_a_DataWr", 64'(a_wr_data), 64'd0);
        check("rst_a_gidx", 64'(a_gidx), 64'd0);
        check("rst_b_RUWr", 64'(b_we), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
        m_out = '{rd: '0, data: '0, we: 1'b0, gidx: '0};
        sb_q.delete();
        for (int i = 0; i < 4; i++) wt[i] = 0;
    endtask

    initial begin
        int w;
        a_valid = '0; a_rd = '0; a_data = '0;
        b_valid = '0; b_rd = '0; b_data = '0;
        rst_n   = 1'b0;
        @(negedge clk);
        reset_all();

        // 3-requester wrap: req2 alone, then req0+req2 -> ptr must fold back to 0.
        b_valid = 3'b100; b_rd[2*AW +: AW] = 5'd7; b_data[2*XLEN +: XLEN] = 32'hCAFE0002;
        #1 check("b_ready_r2", 64'(b_ready), 64'b100);
        @(posedge clk); @(negedge clk); #1;
        check("b_we_r2", 64'(b_we), 64'd1);
        check("b_rd_r2", 64'(b_wr_rd), 64'd7);
        check("b_gidx_r2", 64'(b_gidx), 64'd2);
        b_valid = 3'b101; b_rd[0 +: AW] = 5'd3; b_data[0 +: XLEN] = 32'hCAFE0000;
        #1 check("b_ready_wrap", 64'(b_ready), 64'b001);
        @(posedge clk); @(negedge clk); #1;
        check("b_gidx_wrap", 64'(b_gidx), 64'd0);
        check("b_rd_wrap", 64'(b_wr_rd), 64'd3);
        b_valid = 3'b100;
        #1 check("b_ready_r2b", 64'(b_ready), 64'b100);
        @(posedge clk); @(negedge clk); #1;
        b_valid = 3'b011;
        #1 check("b_ready_wrap2", 64'(b_ready), 64'b001);
        b_valid = '0;

        // Single request with known values, then idle.
        reset_all();
        a_valid = 4'b0001; a_rd[0 +: AW] = 5'd5; a_data[0 +: XLEN] = 32'hDEADBEEF;
        step_a(w);
        check("t1_we", 64'(a_we), 64'd1);
        check("t1_data", 64'(a_wr_data), 64'hDEADBEEF);
        a_valid = '0;
        step_a(w);

        // Two continuously valid requesters alternate.
        reset_all();
        a_rd[0 +: AW] = 5'd1; a_data[0 +: XLEN] = 32'h1111_0000;
        a_rd[AW +: AW] = 5'd2; a_data[XLEN +: XLEN] = 32'h2222_0000;
        a_valid = 4'b0011;
        for (int i = 0; i < 6; i++) begin
            step_a(w);
            check("t2_alt", 64'(w), 64'(i % 2));
        end

        // rd=0 is accepted, never written, and still consumes its turn.
        reset_all();
        a_valid = 4'b0100; a_rd[2*AW +: AW] = 5'd0; a_data[2*XLEN +: XLEN] = 32'h1234;
        step_a(w);
        a_valid = 4'b0110; a_rd[2*AW +: AW] = 5'd9;
        step_a(w);
        check("t3_skip", 64'(w), 64'd1);
        a_valid = '0;

        // Reset while a write is on the bank port and while another is being accepted.
        reset_all();
        a_valid = 4'b0001; a_rd[0 +: AW] = 5'd6;
        step_a(w);
        rst_n = 1'b0;
        #1;
        check("t5_we", 64'(a_we), 64'd0);
        check("t5_rd", 64'(a_wr_rd), 64'd0);
        check("t5_gidx", 64'(a_gidx), 64'd0);
        a_valid = 4'b0011;
        #1 check("t5_ptr0", 64'(a_ready), 64'b0001);
        @(posedge clk); @(negedge clk); #1;
        check("t5_hold_we", 64'(a_we), 64'd0);
        check("t5_hold_rd", 64'(a_wr_rd), 64'd0);
        rst_n = 1'b1;
        m_ptr = 0;
        m_out = '{rd: '0, data: '0, we: 1'b0, gidx: '0};
        sb_q.delete();
        a_valid = '0;
        step_a(w);
        a_valid = 4'b0011;
        step_a(w);

        // Random traffic: requesters hold until granted; wait bounded by NREQ-1 transfers.
        reset_all();
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!a_valid[i] && ($urandom_range(0, 1) == 1)) begin
                    a_valid[i]            = 1'b1;
                    a_rd[i*AW +: AW]      = AW'($urandom_range(0, 31));
                    a_data[i*XLEN +: XLEN] = $urandom;
                    wt[i]                 = 0;
                end
            end
            step_a(w);
            if (w >= 0) begin
                check("fair_wait", 64'(wt[w] <= 3), 64'd1);
                a_valid[w] = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    if (a_valid[i]) wt[i]++;
                end
            end
        end
        a_valid = '0;
        step_a(w);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
